lsu_stage: RTL and testbench

Parametrised, handshaked load/store stage that replaces the purely combinational memory stage. It sits between execute and writeback. It accepts one memory operation at a time from execute over a valid/ready handshake and drives a request/grant/response data-memory port with byte enables. It returns lane-extracted, sign- or zero-extended load data, or the pass-through ALU result, to writeback over a second valid/ready handshake. Unlike the previous stage it tolerates multi-cycle memory latency, supports 64-bit data and detects misaligned accesses.

---
 rtl/lsu_stage_if.sv | 51 +++++
 rtl/lsu_stage.sv | 162 ++++++++++++++++
 tb/tb_lsu_stage.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_stage_if
// Purpose  : Execute-in / data-memory / writeback-out bundle for lsu_stage.
// Revision : 1.0  initial release
// ============================================================================
interface lsu_stage_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    localparam int NBYTES = XLEN / 8;

    logic              in_valid;
    logic              in_ready;
    logic [1:0]        mem_op;
    logic [1:0]        size;
    logic              is_unsigned;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   reg_data;

    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [NBYTES-1:0] dmem_be;
    logic [XLEN-1:0]   dmem_wdata;
    logic              dmem_gnt;
    logic              dmem_rvalid;
    logic [XLEN-1:0]   dmem_rdata;

    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   write_out;
    logic              fault_misaligned;

    // Environment side: execute, data memory and writeback together.
    modport master (
        output in_valid, mem_op, size, is_unsigned, alu_result, reg_data,
        output dmem_gnt, dmem_rvalid, dmem_rdata, out_ready,
        input  in_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  out_valid, write_out, fault_misaligned
    );

    // Stage side.
    modport slave (
        input  in_valid, mem_op, size, is_unsigned, alu_result, reg_data,
        input  dmem_gnt, dmem_rvalid, dmem_rdata, out_ready,
        output in_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output out_valid, write_out, fault_misaligned
    );
endinterface
`default_nettype wire

// File: rtl/lsu_stage.sv
`default_nettype none
// ============================================================================
// Module   : lsu_stage
// Purpose  : Handshaked load/store stage between execute and writeback with
//            byte enables, lane extraction and misalignment detection.
// Revision : 1.0  initial release
// ============================================================================
module lsu_stage #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  wire logic  clk,
    input  wire logic  rst,
    lsu_stage_if.slave bus
);
    localparam int NBYTES = XLEN / 8;
    localparam int OFF_W  = $clog2(NBYTES);

    localparam logic [1:0] c_OP_LOAD  = 2'd1;
    localparam logic [1:0] c_OP_STORE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [1:0]        r_op;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [XLEN-1:0]   r_addr;
    logic [XLEN-1:0]   r_wsrc;
    logic [XLEN-1:0]   r_result;
    logic              r_fault;

    logic              w_accept;
    logic              w_is_mem;
    logic              w_misaligned;
    logic              w_in_req;
    logic              w_is_store;
    logic [OFF_W-1:0]  w_off;
    logic [OFF_W+2:0]  w_shamt;
    logic [XLEN-1:0]   w_lane;
    logic [XLEN-1:0]   w_mask;
    logic              w_sign;
    logic [XLEN-1:0]   w_load;
    logic [XLEN-1:0]   w_wdata;
    logic [NBYTES-1:0] w_be;

    assign w_accept = bus.in_valid && (r_state == S_IDLE);
    assign w_is_mem = (bus.mem_op == c_OP_LOAD) || (bus.mem_op == c_OP_STORE);

    // Alignment is judged on the incoming operands so a faulting access never reaches REQ.
    always_comb begin
        w_misaligned = 1'b0;
        case (bus.size)
            2'd0:    w_misaligned = 1'b0;
            2'd1:    w_misaligned = bus.alu_result[0];
            2'd2:    w_misaligned = |bus.alu_result[1:0];
            default: w_misaligned = (XLEN == 32) || (|bus.alu_result[2:0]);
        endcase
    end

    assign w_off   = r_addr[OFF_W-1:0];
    assign w_shamt = {w_off, 3'b000};
    assign w_lane  = bus.dmem_rdata >> w_shamt;

    // One mask per access size serves both store-lane packing and load extension.
    always_comb begin
        w_mask = '1;
        w_sign = w_lane[XLEN-1];
        w_be   = '1;
        case (r_size)
            2'd0: begin
                w_mask = XLEN'(8'hFF);
                w_sign = w_lane[7];
                w_be   = NBYTES'(1'b1) << w_off;
            end
            2'd1: begin
                w_mask = XLEN'(16'hFFFF);
                w_sign = w_lane[15];
                w_be   = NBYTES'(2'b11) << w_off;
            end
            2'd2: begin
                w_mask = XLEN'(32'hFFFF_FFFF);
                w_sign = w_lane[31];
                w_be   = NBYTES'(4'hF) << w_off;
            end
            default: begin
                w_mask = '1;
                w_sign = w_lane[XLEN-1];
                w_be   = '1;
            end
        endcase
    end

    assign w_load  = (w_lane & w_mask) | ({XLEN{w_sign & ~r_unsigned}} & ~w_mask);
    assign w_wdata = (r_wsrc & w_mask) << w_shamt;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (bus.in_valid)
                        w_next = (!w_is_mem || w_misaligned) ? S_RESP : S_REQ;
            S_REQ:  if (bus.dmem_gnt)
                        w_next = (r_op == c_OP_STORE) ? S_RESP : S_WAIT;
            S_WAIT: if (bus.dmem_rvalid)
                        w_next = S_RESP;
            S_RESP: if (bus.out_ready)
                        w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op       <= 2'd0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wsrc     <= '0;
            r_result   <= '0;
            r_fault    <= 1'b0;
        end else if (w_accept) begin
            r_op       <= bus.mem_op;
            r_size     <= bus.size;
            r_unsigned <= bus.is_unsigned;
            r_addr     <= bus.alu_result;
            r_wsrc     <= bus.reg_data;
            r_fault    <= w_is_mem && w_misaligned;
            r_result   <= w_is_mem ? '0 : bus.alu_result;
        end else if ((r_state == S_WAIT) && bus.dmem_rvalid) begin
            r_result   <= w_load;
        end
    end

    assign w_in_req   = (r_state == S_REQ);
    assign w_is_store = (r_op == c_OP_STORE);

    assign bus.in_ready         = (r_state == S_IDLE) && !rst;
    assign bus.dmem_req         = w_in_req;
    assign bus.dmem_we          = w_in_req && w_is_store;
    assign bus.dmem_addr        = w_in_req ? ADDR_W'(r_addr & ~XLEN'(NBYTES - 1)) : '0;
    assign bus.dmem_be          = w_in_req ? (w_is_store ? w_be : '1) : '0;
    assign bus.dmem_wdata       = (w_in_req && w_is_store) ? w_wdata : '0;
    assign bus.out_valid        = (r_state == S_RESP);
    assign bus.write_out        = (r_state == S_RESP) ? r_result : '0;
    assign bus.fault_misaligned = (r_state == S_RESP) && r_fault;
endmodule
`default_nettype wire

// File: tb/tb_lsu_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_stage
// Purpose  : Randomized self-checking bench driving a 32-bit and a 64-bit
//            lsu_stage through one shared stimulus path.
// Revision : 1.0  initial release
// ============================================================================
module tb_lsu_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_stage_if #(.XLEN(32), .ADDR_W(32)) if32 ();
    lsu_stage_if #(.XLEN(64), .ADDR_W(32)) if64 ();

    lsu_stage #(.XLEN(32), .ADDR_W(32)) u_dut32 (.clk(clk), .rst(rst), .bus(if32));
    lsu_stage #(.XLEN(64), .ADDR_W(32)) u_dut64 (.clk(clk), .rst(rst), .bus(if64));

    logic        r_sel;
    logic        r_in_valid, r_gnt, r_rvalid, r_uns, r_out_ready;
    logic [1:0]  r_op, r_size;
    logic [63:0] r_alu, r_rd, r_rdata;

    // r_sel picks the 64-bit instance; the unselected one never sees in_valid.
    assign if32.in_valid    = r_in_valid & ~r_sel;
    assign if32.mem_op      = r_op;
    assign if32.size        = r_size;
    assign if32.is_unsigned = r_uns;
    assign if32.alu_result  = r_alu[31:0];
    assign if32.reg_data    = r_rd[31:0];
    assign if32.dmem_gnt    = r_gnt & ~r_sel;
    assign if32.dmem_rvalid = r_rvalid & ~r_sel;
    assign if32.dmem_rdata  = r_rdata[31:0];
    assign if32.out_ready   = r_out_ready & ~r_sel;

    assign if64.in_valid    = r_in_valid & r_sel;
    assign if64.mem_op      = r_op;
    assign if64.size        = r_size;
    assign if64.is_unsigned = r_uns;
    assign if64.alu_result  = r_alu;
    assign if64.reg_data    = r_rd;
    assign if64.dmem_gnt    = r_gnt & r_sel;
    assign if64.dmem_rvalid = r_rvalid & r_sel;
    assign if64.dmem_rdata  = r_rdata;
    assign if64.out_ready   = r_out_ready & r_sel;

    logic        w_in_ready, w_req, w_we, w_valid, w_fault;
    logic [31:0] w_addr;
    logic [7:0]  w_be;
    logic [63:0] w_wdata, w_wout;

    assign w_in_ready = r_sel ? if64.in_ready         : if32.in_ready;
    assign w_req      = r_sel ? if64.dmem_req         : if32.dmem_req;
    assign w_we       = r_sel ? if64.dmem_we          : if32.dmem_we;
    assign w_addr     = r_sel ? if64.dmem_addr        : if32.dmem_addr;
    assign w_be       = r_sel ? if64.dmem_be          : {4'b0, if32.dmem_be};
    assign w_wdata    = r_sel ? if64.dmem_wdata       : {32'b0, if32.dmem_wdata};
    assign w_valid    = r_sel ? if64.out_valid        : if32.out_valid;
    assign w_wout     = r_sel ? if64.write_out        : {32'b0, if32.write_out};
    assign w_fault    = r_sel ? if64.fault_misaligned : if32.fault_misaligned;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One operation end to end; expectations come from byte-lane arithmetic.
    task automatic run_op(input bit sel, input logic [1:0] op, input logic [1:0] size,
                          input bit uns, input logic [63:0] alu, input logic [63:0] rd,
                          input logic [63:0] rdata, input int gdly, input int rdly,
                          input int bp);
        int          xl, nb, o, nbytes, lat_exp, reqs_exp, cyc, reqs, rvcnt;
        bit          mem, mis, waiting, done;
        logic [63:0] xmask, dmask, v, res_exp, wdata_exp, rd_in;
        logic [31:0] addr_exp;
        logic [7:0]  be_exp;
        xl      = sel ? 64 : 32;
        nb      = xl / 8;
        o       = int'(alu[2:0]) % nb;
        nbytes  = 1 << size;
        xmask   = sel ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        dmask   = (nbytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nbytes)) - 64'd1);
        mem     = (op == 2'd1) || (op == 2'd2);
        mis     = mem && (((size == 2'd3) && (xl == 32)) || ((int'(alu[2:0]) % nbytes) != 0));
        addr_exp = alu[31:0] & ~32'(nb - 1);
        be_exp  = (op == 2'd2) ? 8'((((1 << nbytes) - 1) << o) & ((1 << nb) - 1))
                               : 8'((1 << nb) - 1);
        wdata_exp = (op == 2'd2) ? (((rd & dmask) << (8 * o)) & xmask) : 64'd0;
        rd_in   = rdata & xmask;
        v       = (rd_in >> (8 * o)) & dmask;
        if (!uns && v[8 * nbytes - 1]) v = v | ~dmask;
        v       = v & xmask;
        res_exp = !mem ? (alu & xmask) : ((mis || op == 2'd2) ? 64'd0 : v);
        reqs_exp = (mem && !mis) ? gdly + 1 : 0;
        lat_exp = (!mem || mis) ? 1 : ((op == 2'd2) ? 2 + gdly : 3 + gdly + rdly);

        @(negedge clk);
        r_sel = sel; r_op = op; r_size = size; r_uns = uns; r_alu = alu; r_rd = rd;
        r_in_valid = 1'b1;
        chk("in_ready_idle", 64'(sel ? if64.in_ready : if32.in_ready), 64'd1);
        @(negedge clk);
        r_in_valid = 1'b0;
        r_alu = {$urandom, $urandom};
        r_rd  = {$urandom, $urandom};
        cyc = 1; reqs = 0; rvcnt = 0; waiting = 0; done = 0;
        while (!done && cyc < 100) begin
            r_gnt = 1'b0; r_rvalid = 1'b0;
            if (w_valid) begin
                done = 1;
            end else begin
                r_out_ready = 1'($urandom_range(0, 1));
                if (w_req) begin
                    reqs++;
                    chk("dmem_addr", 64'(w_addr), 64'(addr_exp));
                    chk("dmem_be", 64'(w_be), 64'(be_exp));
                    chk("dmem_we", 64'(w_we), 64'(op == 2'd2));
                    if (op == 2'd2) chk("dmem_wdata", w_wdata, wdata_exp);
                    if (reqs > gdly) begin
                        r_gnt = 1'b1;
                        if (op == 2'd1) waiting = 1;
                    end else if ($urandom_range(0, 2) == 0) begin
                        r_rvalid = 1'b1;
                        r_rdata  = {$urandom, $urandom};
                    end
                end else if (waiting) begin
                    if (rvcnt == rdly) begin
                        r_rvalid = 1'b1;
                        r_rdata  = rdata;
                        waiting  = 0;
                    end else begin
                        rvcnt++;
                        r_rdata = {$urandom, $urandom};
                    end
                end
                @(negedge clk);
                cyc++;
            end
        end
        r_out_ready = 1'b0;
        chk("out_valid", 64'(w_valid), 64'd1);
        chk("latency", 64'(cyc), 64'(lat_exp));
        chk("req_cycles", 64'(reqs), 64'(reqs_exp));
        chk("write_out", w_wout, res_exp);
        chk("fault", 64'(w_fault), 64'(mis));
        for (int i = 0; i < bp; i++) begin
            r_rvalid = 1'($urandom_range(0, 1));
            r_rdata  = {$urandom, $urandom};
            @(negedge clk);
            chk("bp_valid", 64'(w_valid), 64'd1);
            chk("bp_write_out", w_wout, res_exp);
            chk("bp_in_ready", 64'(w_in_ready), 64'd0);
        end
        r_rvalid    = 1'b0;
        r_out_ready = 1'b1;
        @(negedge clk);
        r_out_ready = 1'b0;
        chk("post_valid", 64'(w_valid), 64'd0);
        chk("post_in_ready", 64'(w_in_ready), 64'd1);
    endtask

    task automatic reset_in_wait();
        @(negedge clk);
        r_sel = 1'b0; r_op = 2'd1; r_size = 2'd2; r_uns = 1'b0; r_alu = 64'h100;
        r_in_valid = 1'b1;
        @(negedge clk);
        r_in_valid = 1'b0;
        chk("rst_req", 64'(w_req), 64'd1);
        r_gnt = 1'b1;
        @(negedge clk);
        r_gnt = 1'b0;
        chk("rst_wait_req", 64'(w_req), 64'd0);
        rst = 1'b1;
        #1;
        chk("rst_valid", 64'(w_valid), 64'd0);
        chk("rst_in_ready", 64'(w_in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        r_rvalid = 1'b1;
        r_rdata  = 64'hDEAD_BEEF;
        @(negedge clk);
        r_rvalid = 1'b0;
        chk("late_rv_valid", 64'(w_valid), 64'd0);
        chk("late_rv_in_ready", 64'(w_in_ready), 64'd1);
        @(negedge clk);
        chk("late_rv_valid2", 64'(w_valid), 64'd0);
    endtask

    initial begin
        bit          sel;
        logic [1:0]  op, size;
        logic [63:0] alu;
        rst = 1'b1;
        r_sel = 1'b0; r_in_valid = 1'b0; r_gnt = 1'b0; r_rvalid = 1'b0; r_uns = 1'b0;
        r_out_ready = 1'b0; r_op = 2'd0; r_size = 2'd0;
        r_alu = 64'd0; r_rd = 64'd0; r_rdata = 64'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 64'(w_in_ready), 64'd1);
        chk("reset_valid", 64'(w_valid), 64'd0);
        chk("reset_req", 64'(w_req), 64'd0);
        chk("reset_write_out", w_wout, 64'd0);
        chk("reset_fault", 64'(w_fault), 64'd0);

        run_op(0, 2'd0, 2'd2, 0, 64'h1234_5678, 64'd0, 64'd0, 0, 0, 0);
        run_op(0, 2'd1, 2'd0, 0, 64'h103, 64'd0, 64'h80FF_0000, 0, 0, 0);
        run_op(0, 2'd1, 2'd0, 1, 64'h103, 64'd0, 64'h80FF_0000, 0, 0, 0);
        run_op(0, 2'd2, 2'd1, 0, 64'h202, 64'hAAAA_BEEF, 64'd0, 4, 0, 0);
        run_op(0, 2'd1, 2'd2, 0, 64'h101, 64'd0, 64'hFFFF_FFFF, 0, 0, 0);
        run_op(0, 2'd0, 2'd0, 0, 64'hCAFE_F00D, 64'd0, 64'd0, 0, 0, 5);
        run_op(0, 2'd1, 2'd1, 0, 64'h306, 64'd0, 64'h9ABC_1234, 1, 2, 5);
        run_op(0, 2'd2, 2'd3, 0, 64'h400, 64'h1111_2222, 64'd0, 0, 0, 0);
        reset_in_wait();
        run_op(1, 2'd1, 2'd2, 1, 64'h4, 64'd0, 64'hF000_0000_0000_0000, 0, 0, 0);
        run_op(1, 2'd1, 2'd2, 0, 64'h4, 64'd0, 64'hF000_0000_0000_0000, 0, 0, 0);
        run_op(1, 2'd2, 2'd3, 0, 64'h1000, 64'h0123_4567_89AB_CDEF, 64'd0, 2, 0, 1);
        run_op(1, 2'd1, 2'd3, 0, 64'h1004, 64'd0, 64'd0, 0, 0, 0);

        for (int n = 0; n < 200; n++) begin
            sel  = 1'($urandom_range(0, 1));
            op   = 2'($urandom_range(0, 3));
            size = 2'($urandom_range(0, 3));
            alu  = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) alu = alu & ~64'((1 << size) - 1);
            run_op(sel, op, size, 1'($urandom_range(0, 1)), alu, {$urandom, $urandom},
                   {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
